// File: rtl/bb_scrambler_pkg.sv
// Shared constants, types and the reference LFSR step for the DVB-S2 BBFRAME scrambler.
package bb_scrambler_pkg;

    localparam int unsigned PRBS_LEN      = 15;
    localparam int unsigned PRBS_MAX_BITS = 64;

    // Bit 0 holds r1.
    localparam logic [PRBS_LEN-1:0] PRBS_INIT = 15'b000000010101001;

    typedef enum logic [0:0] {
        StIdle,
        StActive
    } frame_state_e;

    typedef struct packed {
        logic [PRBS_LEN-1:0]      state;
        logic [PRBS_MAX_BITS-1:0] bits;
    } prbs_step_t;

    // Advances the 1 + X^14 + X^15 LFSR by n steps; bit i of .bits is the i-th PRBS bit.
    function automatic prbs_step_t prbs_step(input logic [PRBS_LEN-1:0] state,
                                             input int unsigned n);
        prbs_step_t          res;
        logic [PRBS_LEN-1:0] r;
        logic                b;
        r        = state;
        res.bits = '0;
        for (int unsigned i = 0; i < PRBS_MAX_BITS; i++) begin
            if (i < n) begin
                b           = r[PRBS_LEN-2] ^ r[PRBS_LEN-1];
                res.bits[i] = b;
                r           = {r[PRBS_LEN-2:0], b};
            end
        end
        res.state = r;
        return res;
    endfunction

endpackage

// File: rtl/bb_prbs_generator.sv
// Combinational parallel LFSR: produces one word of PRBS bits and the state after that word.
module bb_prbs_generator
    import bb_scrambler_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 32
) (
    input  logic [PRBS_LEN-1:0]    state_i,
    input  logic                   restart_i,
    output logic [TDATA_WIDTH-1:0] prbs_o,
    output logic [PRBS_LEN-1:0]    state_o
);

    prbs_step_t step;
    logic       unused_bits_parity;

    always_comb begin
        step    = prbs_step(restart_i ? PRBS_INIT : state_i, TDATA_WIDTH);
        prbs_o  = step.bits[TDATA_WIDTH-1:0];
        state_o = step.state;
    end

    // Bits beyond TDATA_WIDTH are always zero.
    assign unused_bits_parity = ^step.bits;

endmodule

// File: rtl/bb_scrambler.sv
// DVB-S2 BBFRAME scrambler: one-stage AXI-Stream pipeline, PRBS restarted at every frame start.
module bb_scrambler
    import bb_scrambler_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH       = 32,
    parameter int unsigned FRAME_COUNT_WIDTH = 16
) (
    input  logic                         data_in_aclk,
    input  logic                         data_in_aresetn,
    output logic                         data_in_tready,
    input  logic [TDATA_WIDTH-1:0]       data_in_tdata,
    input  logic                         data_in_tlast,
    input  logic                         data_in_tvalid,
    input  logic                         data_out_tready,
    output logic [TDATA_WIDTH-1:0]       data_out_tdata,
    output logic                         data_out_tlast,
    output logic                         data_out_tvalid,
    input  logic                         scrambler_enable,
    output logic [FRAME_COUNT_WIDTH-1:0] frame_count
);

    frame_state_e                 frame_state_q, frame_state_d;
    logic [PRBS_LEN-1:0]          lfsr_q, lfsr_d;
    logic                         en_frame_q, en_frame_d;
    logic [TDATA_WIDTH-1:0]       tdata_q, tdata_d;
    logic                         tlast_q, tlast_d;
    logic                         tvalid_q, tvalid_d;
    logic [FRAME_COUNT_WIDTH-1:0] frame_count_q, frame_count_d;

    logic                   hs_in;
    logic                   hs_out;
    logic                   frame_start;
    logic                   en_word;
    logic [TDATA_WIDTH-1:0] prbs_bits;
    logic [PRBS_LEN-1:0]    lfsr_next;

    assign data_in_tready  = ~tvalid_q | data_out_tready;
    assign hs_in           = data_in_tvalid & data_in_tready;
    assign hs_out          = tvalid_q & data_out_tready;

    assign data_out_tdata  = tdata_q;
    assign data_out_tlast  = tlast_q;
    assign data_out_tvalid = tvalid_q;
    assign frame_count     = frame_count_q;

    bb_prbs_generator #(
        .TDATA_WIDTH(TDATA_WIDTH)
    ) u_prbs (
        .state_i  (lfsr_q),
        .restart_i(frame_start),
        .prbs_o   (prbs_bits),
        .state_o  (lfsr_next)
    );

    always_ff @(posedge data_in_aclk or negedge data_in_aresetn) begin
        if (!data_in_aresetn) begin
            frame_state_q <= StIdle;
        end else begin
            frame_state_q <= frame_state_d;
        end
    end

    always_comb begin
        frame_state_d = frame_state_q;
        if (hs_in) begin
            frame_state_d = data_in_tlast ? StIdle : StActive;
        end
    end

    always_comb begin
        frame_start = (frame_state_q == StIdle);
    end

    // Enable is only sampled on the first word of a frame.
    always_comb begin
        en_word       = frame_start ? scrambler_enable : en_frame_q;
        lfsr_d        = lfsr_q;
        en_frame_d    = en_frame_q;
        tdata_d       = tdata_q;
        tlast_d       = tlast_q;
        tvalid_d      = tvalid_q;
        frame_count_d = frame_count_q;
        if (hs_in) begin
            lfsr_d     = lfsr_next;
            en_frame_d = en_word;
            tdata_d    = en_word ? (data_in_tdata ^ prbs_bits) : data_in_tdata;
            tlast_d    = data_in_tlast;
            tvalid_d   = 1'b1;
        end else if (hs_out) begin
            tvalid_d = 1'b0;
        end
        if (hs_out && tlast_q) begin
            frame_count_d = frame_count_q + FRAME_COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge data_in_aclk or negedge data_in_aresetn) begin
        if (!data_in_aresetn) begin
            lfsr_q        <= PRBS_INIT;
            en_frame_q    <= 1'b0;
            tdata_q       <= '0;
            tlast_q       <= 1'b0;
            tvalid_q      <= 1'b0;
            frame_count_q <= '0;
        end else begin
            lfsr_q        <= lfsr_d;
            en_frame_q    <= en_frame_d;
            tdata_q       <= tdata_d;
            tlast_q       <= tlast_d;
            tvalid_q      <= tvalid_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule
